// File: rtl/pcs_transmit.sv
// rtl/pcs_transmit.sv - 1000BASE-X PCS transmit: ordered-set FSM, even/odd alignment, RD tracking, 8b/10b encoder
// Optional macro PCS_ERR_PROP_EN: TX_ER inside a packet emits /V/ (K30.7) instead of /D/.
module pcs_transmit (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [7:0] TXD,
    output logic [9:0] tx_code_group,
    output logic       transmitting
);

    // Special code groups in their RD- column; the RD+ column is the bitwise complement.
    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K27_7 = 10'b1101101000;
    localparam logic [9:0] K29_7 = 10'b1011101000;
    localparam logic [9:0] K23_7 = 10'b1110101000;
    localparam logic [9:0] K30_7 = 10'b0111101000;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    typedef enum logic [1:0] {IDLE, DATA, EPD2, EPD3} state_t;

    state_t     state_q, state_d;
    logic [9:0] cg_q, cg_d;
    logic       tx_q, tx_d;
    logic       rd_q, rd_d;
    logic       odd_q;

    function automatic logic [9:0] k_code(input logic [9:0] neg, input logic rd);
        return rd ? ~neg : neg;
    endfunction

    function automatic logic [9:0] enc_data(input logic [7:0] d, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        x = d[4:0];
        y = d[7:5];
        case (x)
            5'd0:  c6 = 6'b100111;
            5'd1:  c6 = 6'b011101;
            5'd2:  c6 = 6'b101101;
            5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;
            5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;
            5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;
            5'd9:  c6 = 6'b100101;
            5'd10: c6 = 6'b010101;
            5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;
            5'd13: c6 = 6'b101100;
            5'd14: c6 = 6'b011100;
            5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;
            5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;
            5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;
            5'd21: c6 = 6'b101010;
            5'd22: c6 = 6'b011010;
            5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;
            5'd25: c6 = 6'b100110;
            5'd26: c6 = 6'b010110;
            5'd27: c6 = 6'b110110;
            5'd28: c6 = 6'b001110;
            5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;
            default: c6 = 6'b101011;
        endcase
        // D.07 is neutral yet still has a distinct RD+ form.
        if (rd && (($countones(c6) != 3) || (x == 5'd7)))
            c6 = ~c6;
        rd_mid = ($countones(c6) == 3) ? rd : ($countones(c6) > 3);
        case (y)
            3'd0: c4 = 4'b1011;
            3'd1: c4 = 4'b1001;
            3'd2: c4 = 4'b0101;
            3'd3: c4 = 4'b1100;
            3'd4: c4 = 4'b1101;
            3'd5: c4 = 4'b1010;
            3'd6: c4 = 4'b0110;
            default: begin
                // A7 avoids a run of five identical bits across the sub-block boundary.
                if ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                    ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)))
                    c4 = 4'b0111;
                else
                    c4 = 4'b1110;
            end
        endcase
        if (rd_mid && (($countones(c4) != 2) || (y == 3'd3)))
            c4 = ~c4;
        return {c6, c4};
    endfunction

    always_comb begin
        state_d = state_q;
        cg_d    = k_code(K28_5, rd_q);
        tx_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (odd_q) begin
                    // RD+ here means the even K28.5 was sent RD-, so I2 restores RD-.
                    cg_d = enc_data(rd_q ? D16_2 : D5_6, rd_q);
                end else if (TX_EN) begin
                    cg_d    = k_code(K27_7, rd_q);
                    tx_d    = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (TX_EN) begin
                    tx_d = 1'b1;
`ifdef PCS_ERR_PROP_EN
                    cg_d = TX_ER ? k_code(K30_7, rd_q) : enc_data(TXD, rd_q);
`else
                    cg_d = enc_data(TXD, rd_q);
`endif
                end else begin
                    cg_d    = k_code(K29_7, rd_q);
                    state_d = EPD2;
                end
            end
            EPD2: begin
                cg_d    = k_code(K23_7, rd_q);
                state_d = odd_q ? IDLE : EPD3;
            end
            default: begin
                cg_d    = k_code(K23_7, rd_q);
                state_d = IDLE;
            end
        endcase
        // Net disparity of the whole group decides the running disparity afterwards.
        if ($countones(cg_d) == 5)
            rd_d = rd_q;
        else
            rd_d = ($countones(cg_d) > 5);
    end

`ifndef PCS_ERR_PROP_EN
    logic unused_tx_er;
    assign unused_tx_er = TX_ER;
`endif

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= IDLE;
            cg_q    <= K28_5;
            tx_q    <= 1'b0;
            rd_q    <= 1'b1;
            odd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cg_q    <= cg_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            odd_q   <= ~odd_q;
        end
    end

    assign tx_code_group = cg_q;
    assign transmitting  = tx_q;

endmodule

// File: tb/tb_pcs_transmit.sv
// tb/tb_pcs_transmit.sv - directed self-checking bench for pcs_transmit
module tb_pcs_transmit;

    logic       clk;
    logic       rst_n;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
    logic [9:0] cg;
    logic       xmit;

    int tests;
    int fails;

    localparam logic [9:0] K28_5N = 10'b0011111010;
    localparam logic [9:0] K28_5P = 10'b1100000101;
    localparam logic [9:0] K27_7N = 10'b1101101000;
    localparam logic [9:0] K29_7N = 10'b1011101000;
    localparam logic [9:0] K29_7P = 10'b0100010111;
    localparam logic [9:0] K23_7N = 10'b1110101000;
    localparam logic [9:0] K23_7P = 10'b0001010111;
    localparam logic [9:0] D16_2P = 10'b1001000101;
    localparam logic [9:0] D5_6N  = 10'b1010010110;
    localparam logic [9:0] D21_2  = 10'b1010100101;
`ifdef PCS_ERR_PROP_EN
    localparam logic [9:0] ERR_SLOT = 10'b1000010111;
`else
    localparam logic [9:0] ERR_SLOT = 10'b1010100101;
`endif

    pcs_transmit dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst_n),
        .TX_EN         (tx_en),
        .TX_ER         (tx_er),
        .TXD           (txd),
        .tx_code_group (cg),
        .transmitting  (xmit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] exp_cg, input logic exp_tx);
        tests = tests + 1;
        assert (cg === exp_cg) else begin
            fails = fails + 1;
            $error("FAIL %s code_group got %b want %b", tag, cg, exp_cg);
        end
        tests = tests + 1;
        assert (xmit === exp_tx) else begin
            fails = fails + 1;
            $error("FAIL %s transmitting got %b want %b", tag, xmit, exp_tx);
        end
    endtask

    task automatic step(input logic en, input logic er, input logic [7:0] d,
                        input logic [9:0] exp_cg, input logic exp_tx, input string tag);
        tx_en = en;
        tx_er = er;
        txd   = d;
        @(posedge clk);
        #1;
        check(tag, exp_cg, exp_tx);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd   = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", K28_5N, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 8'h00, D16_2P, 0, "idle_odd1");
        step(0, 0, 8'h00, K28_5N, 0, "idle_even2");
        step(0, 0, 8'h00, D16_2P, 0, "idle_odd3");

        // Packet 1: /T/ in an even slot, all octets end RD-.
        step(1, 0, 8'h55, K27_7N, 1, "sop1");
        for (int i = 0; i < 6; i++)
            step(1, 0, 8'h55, D21_2, 1, "d21_2");
        step(1, 0, 8'hD5, 10'b1010100110, 1, "d21_6");
        step(1, 0, 8'h01, 10'b0111010100, 1, "d1_0");
        step(1, 0, 8'h02, 10'b1011010100, 1, "d2_0");
        step(0, 0, 8'h00, K29_7N, 0, "t_even");
        step(0, 0, 8'h00, K23_7N, 0, "r_odd");
        step(0, 0, 8'h00, K28_5N, 0, "idle_after_t_even");
        step(0, 0, 8'h00, D16_2P, 0, "idle_odd_after1");

        // TX_EN rising in an odd slot: pair completes, octet dropped.
        step(0, 0, 8'h00, K28_5N, 0, "idle_even18");
        step(1, 0, 8'hAA, D16_2P, 0, "odd_rise");
        step(1, 0, 8'hAA, K27_7N, 1, "sop2");
        step(1, 0, 8'h20, 10'b1001111001, 1, "d0_1_rdp");
        step(1, 1, 8'h55, ERR_SLOT, 1, "tx_er_slot");
        step(0, 0, 8'h00, K29_7P, 0, "t_odd");
        step(1, 0, 8'h33, K23_7P, 0, "r_even_ignored_en");
        step(1, 0, 8'h33, K23_7P, 0, "r_odd_ignored_en");
        step(0, 0, 8'h00, K28_5P, 0, "idle_k28_5p");
        step(0, 0, 8'h00, D5_6N, 0, "idle_d5_6");
        step(0, 0, 8'h00, K28_5N, 0, "idle_even28");
        step(0, 0, 8'h00, D16_2P, 0, "idle_odd29");

        // Packet 3: alternate A7 and D7 codes, then reset mid-packet.
        step(1, 0, 8'h00, K27_7N, 1, "sop3");
        step(1, 0, 8'hF1, 10'b1000110111, 1, "d17_7_alt");
        step(1, 0, 8'hEB, 10'b1101001000, 1, "d11_7_alt");
        step(1, 0, 8'h07, 10'b1110001011, 1, "d7_0");
        step(1, 0, 8'h67, 10'b0001110011, 1, "d7_3_rdp");

        rst_n = 1'b0;
        #1;
        check("reset_mid_packet", K28_5N, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 8'h00, D16_2P, 0, "post_reset_odd");
        step(0, 0, 8'h00, K28_5N, 0, "post_reset_even");
        step(0, 0, 8'h00, D16_2P, 0, "post_reset_odd2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pcs_transmit.md
Name: pcs_transmit

Overview:
- 1000BASE-X PCS transmit path: takes GMII-style octets (TX_EN, TX_ER, TXD) and emits one 10-bit 8b/10b code group per GTX_CLK cycle.
- Contains the transmit ordered-set state machine (/I/, /S/, /D/, /T/, /R/, /V/), even/odd code-group alignment, running-disparity tracking and the 8b/10b encoder.
- Sits between the MAC-side GMII stimulus and the serializer.
- Link is permanently in DATA mode: no auto-negotiation, no configuration ordered sets.

Parameters:
- none

Ports:
- GTX_CLK  input  1  transmit clock; all state updates on its rising edge.
- mr_main_reset  input  1  asynchronous, active-low reset.
- TX_EN  input  1  GMII transmit enable; high marks packet octets.
- TX_ER  input  1  GMII transmit error; see Optional Feature.
- TXD  input  8  GMII transmit octet.
- tx_code_group  output  10  registered code group; bit9=a … bit0=j (abcdei fghj).
- transmitting  output  1  registered; high while a packet is on tx_code_group.

Behaviour:
- Clock and reset: one clock (GTX_CLK); reset mr_main_reset is asynchronous and active-low.
- Reset values:
  - tx_code_group = K28.5 RD- (0011111010); transmitting = 0.
  - Running disparity (RD) = positive; next slot = odd; state = IDLE.
  - Asserting reset mid-packet aborts immediately to these values.
- Latency: inputs sampled at edge k determine tx_code_group after edge k. Single register stage; RD and the even/odd toggle update on the same edge.
- Alignment:
  - Every code group alternates even/odd.
  - K28.5 and /S/ are emitted only in even slots.
  - /T/ is emitted in any slot; the following /R/ padding returns to even.
- States:
  - IDLE:
    - Even slot: emit K28.5 using current RD.
    - Odd slot: emit D5.6 (I1) if RD was positive at the even slot, else D16.2 (I2). Either way RD is negative after the ordered set.
    - At an even slot with TX_EN=1: emit /S/ K27.7 instead of K28.5, set transmitting=1, go to DATA. TXD of that cycle is dropped (replaced by /S/).
    - TX_EN rising in an odd slot: the odd slot completes the idle pair, and its TXD octet is dropped.
  - DATA:
    - TX_EN=1: emit /D/ = 8b/10b of TXD (Dx.y, x=TXD[4:0], y=TXD[7:5]).
    - TX_EN=0: emit /T/ K29.7, transmitting=0, go to EPD2.
  - EPD2: emit /R/ K23.7. If this slot is odd, go to IDLE; if even, go to EPD3.
  - EPD3: emit /R/ K23.7, go to IDLE. The next code group is an even K28.5.
  - TX_EN reasserted during EPD2/EPD3: ignored; the packet starts only from IDLE.
- Encoder:
  - Full IEEE 802.3 Clause 36 tables: 5b/6b and 3b/4b sub-blocks, RD-selected column.
  - Dx.A7 alternate 0111/1000 used for x=17,18,20 when RD-, and x=11,13,14 when RD+.
  - RD updates after each sub-block: non-neutral flips it; neutral keeps it.
  - Special codes:
    - K28.5: RD- 0011111010, RD+ 1100000101.
    - K27.7: RD- 1101101000, RD+ 0010010111.
    - K29.7: RD- 1011101000, RD+ 0100010111.
    - K23.7: RD- 1110101000, RD+ 0001010111.
    - K30.7: RD- 0111101000, RD+ 1000010111.
- Outside a packet, TX_ER and TXD are ignored (no carrier extension).

Optional Feature:
- Macro PCS_ERR_PROP_EN.
- Defined: in DATA with TX_EN=1 and TX_ER=1, emit /V/ K30.7 in place of /D/; transmitting stays 1.
- Undefined: TX_ER is ignored everywhere and that octet is encoded as /D/.

Test Plan:
- Reset low, then release, TX_EN=0 → K28.5- held during reset; then 1001000101 (D16.2+); then repeating 0011111010, 1001000101 pairs; transmitting=0.
- After reset, raise TX_EN at an even slot with TXD=0x55×7, 0xD5, 0x01, 0x02 → K27.7 /S/ then D21.2 (1010100101)… with correct RD columns; transmitting=1 from /S/ through last /D/.
- Drop TX_EN so /T/ lands in an odd slot → /T/, /R/, /R/, then K28.5 in the even slot. Repeat with /T/ in an even slot → /T/, /R/, then K28.5.
- Packet ending with RD+ → following idle is K28.5+ (1100000101) then D5.6 (1010010110); RD- afterwards.
- With PCS_ERR_PROP_EN, assert TX_ER for one octet mid-packet → K30.7 in that slot; without the macro → the normal /D/ for that TXD.
- Assert reset mid-packet → tx_code_group=0011111010 and transmitting=0 immediately; clean idle stream after release.
